// File: rtl/alu_sb_pkg.sv
// Shared defaults, counter width, FSM state type and helpers for the ALU scoreboard.
package alu_sb_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } sb_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/alu_sb_fifo.sv
// Expected-result queue: power-of-two ring buffer with synchronous flush.
module alu_sb_fifo
    import alu_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/alu_scoreboard.sv
// In-order ALU result scoreboard with registered compare outcome.
// Optional ALU_SB_HALT_EN: freeze the scoreboard on the first mismatch.
module alu_scoreboard
    import alu_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exp_valid,
    input  logic [DATA_W-1:0]        exp_data,
    output logic                     exp_ready,
    input  logic                     act_valid,
    input  logic [DATA_W-1:0]        act_data,
    input  logic                     flush,
    output logic                     match_pulse,
    output logic                     mismatch_pulse,
    output logic [DATA_W-1:0]        mis_exp,
    output logic [DATA_W-1:0]        mis_act,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     halted
);

`ifdef ALU_SB_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    sb_state_t         state;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              live;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              do_cmp;
    logic              cmp_eq;
    logic [DATA_W-1:0] cmp_exp;
    logic              ovf_ev;
    logic              unf_ev;

`ifdef ALU_SB_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    // Flush and halt both suppress every queue action and event for the cycle.
    assign live   = !flush && !halted;
    assign pop    = live && act_valid && !empty;
    assign bypass = live && act_valid && empty && exp_valid;
    // A full queue still accepts a push when a pop frees a slot in the same cycle.
    assign push   = live && exp_valid && !bypass && (!full || act_valid);
    assign ovf_ev = live && exp_valid && full && !act_valid;
    assign unf_ev = live && act_valid && empty && !exp_valid;

    assign do_cmp    = pop || bypass;
    assign cmp_exp   = empty ? exp_data : head;
    assign cmp_eq    = (cmp_exp == act_data);
    assign exp_ready = !full && !halted;

    alu_sb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (exp_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            match_pulse    <= 1'b0;
            mismatch_pulse <= 1'b0;
            match_cnt      <= '0;
            err_cnt        <= '0;
            mis_exp        <= '0;
            mis_act        <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            match_pulse    <= do_cmp && cmp_eq;
            mismatch_pulse <= do_cmp && !cmp_eq;
            if (do_cmp && cmp_eq) match_cnt <= sat_inc(match_cnt);
            if (do_cmp && !cmp_eq) begin
                err_cnt <= sat_inc(err_cnt);
                mis_exp <= cmp_exp;
                mis_act <= act_data;
            end
            if (ovf_ev) overflow  <= 1'b1;
            if (unf_ev) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (HALT_EN && do_cmp && !cmp_eq) state <= HALT;
                    else if (push)                    state <= RUN;
                end
                RUN: begin
                    if (flush)                             state <= IDLE;
                    else if (HALT_EN && do_cmp && !cmp_eq) state <= HALT;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scoreboard.sv
// Randomised and directed checks of alu_scoreboard against a queue-based reference model.
module tb_alu_scoreboard;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

`ifdef ALU_SB_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              exp_ready;
    logic              act_valid;
    logic [DATA_W-1:0] act_data;
    logic              flush;
    logic              match_pulse;
    logic              mismatch_pulse;
    logic [DATA_W-1:0] mis_exp;
    logic [DATA_W-1:0] mis_act;
    logic [15:0]       match_cnt;
    logic [15:0]       err_cnt;
    logic              overflow;
    logic              underflow;
    logic [3:0]        level;
    logic              halted;

    alu_scoreboard #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .exp_valid      (exp_valid),
        .exp_data       (exp_data),
        .exp_ready      (exp_ready),
        .act_valid      (act_valid),
        .act_data       (act_data),
        .flush          (flush),
        .match_pulse    (match_pulse),
        .mismatch_pulse (mismatch_pulse),
        .mis_exp        (mis_exp),
        .mis_act        (mis_act),
        .match_cnt      (match_cnt),
        .err_cnt        (err_cnt),
        .overflow       (overflow),
        .underflow      (underflow),
        .level          (level),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];
    bit                m_halt, m_mp, m_mm, m_ov, m_un;
    int unsigned       m_mc, m_ec;
    logic [DATA_W-1:0] m_me, m_ma;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_halt = 0; m_mp = 0; m_mm = 0; m_ov = 0; m_un = 0;
        m_mc = 0; m_ec = 0; m_me = '0; m_ma = '0;
    endtask

    task automatic model_step(input bit ev, input logic [DATA_W-1:0] ed,
                              input bit av, input logic [DATA_W-1:0] ad, input bit fl);
        logic [DATA_W-1:0] e;
        bit has;
        m_mp = 0; m_mm = 0; has = 0; e = '0;
        if (fl) begin
            mq.delete();
        end else if (!m_halt) begin
            if (av) begin
                if (mq.size() > 0) begin
                    e = mq.pop_front(); has = 1;
                    if (ev) mq.push_back(ed);
                end else if (ev) begin
                    e = ed; has = 1;
                end else begin
                    m_un = 1;
                end
            end else if (ev) begin
                if (mq.size() < DEPTH) mq.push_back(ed);
                else m_ov = 1;
            end
            if (has) begin
                if (e == ad) begin
                    m_mp = 1;
                    if (m_mc < 65535) m_mc++;
                end else begin
                    m_mm = 1;
                    if (m_ec < 65535) m_ec++;
                    m_me = e; m_ma = ad;
                    if (HALT_EN) m_halt = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check("match_pulse",    match_pulse,    m_mp);
        check("mismatch_pulse", mismatch_pulse, m_mm);
        check("match_cnt",      match_cnt,      m_mc);
        check("err_cnt",        err_cnt,        m_ec);
        check("overflow",       overflow,       m_ov);
        check("underflow",      underflow,      m_un);
        check("level",          level,          mq.size());
        check("exp_ready",      exp_ready,      (mq.size() < DEPTH) && !m_halt);
        check("halted",         halted,         m_halt);
        check("mis_exp",        mis_exp,        m_me);
        check("mis_act",        mis_act,        m_ma);
    endtask

    task automatic cycle(input bit ev, input logic [DATA_W-1:0] ed,
                         input bit av, input logic [DATA_W-1:0] ad, input bit fl);
        exp_valid = ev; exp_data = ed; act_valid = av; act_data = ad; flush = fl;
        model_step(ev, ed, av, ad, fl);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1; exp_valid = 0; exp_data = '0; act_valid = 0; act_data = '0; flush = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        check_all();
    endtask

    initial begin
        rst = 1; exp_valid = 0; exp_data = '0; act_valid = 0; act_data = '0; flush = 0;
        model_reset();

        // Basic in-order matching
        do_reset();
        cycle(1, 3, 0, 0, 0);
        cycle(1, 6, 0, 0, 0);
        cycle(1, 9, 0, 0, 0);
        cycle(0, 0, 1, 3, 0);
        cycle(0, 0, 1, 6, 0);
        cycle(0, 0, 1, 9, 0);
        check("seq_match_cnt", match_cnt, 3);
        check("seq_err_cnt",   err_cnt,   0);
        check("seq_level",     level,     0);

        // Single mismatch
        do_reset();
        cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 1, 7, 0);
        check("mis_pulse",   mismatch_pulse, 1);
        check("mis_exp_5",   mis_exp,        5);
        check("mis_act_7",   mis_act,        7);
        check("mis_err_cnt", err_cnt,        1);
        check("mis_halted",  halted,         HALT_EN);
        check("mis_ready",   exp_ready,      !HALT_EN);

        // Bypass on empty queue
        do_reset();
        cycle(1, 32'h10, 1, 32'h10, 0);
        check("byp_match", match_pulse, 1);
        check("byp_level", level,       0);
        check("byp_unf",   underflow,   0);

        // Fill, overflow, then full push+pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 100 + i, 0, 0, 0);
        cycle(1, 200, 0, 0, 0);
        check("ovf_flag",  overflow, 1);
        check("ovf_level", level,    8);
        cycle(1, 201, 1, 100, 0);
        check("full_pp_level", level,       8);
        check("full_pp_match", match_pulse, 1);
        check("full_pp_err",   err_cnt,     0);

        // Underflow
        do_reset();
        cycle(0, 0, 1, 5, 0);
        check("unf_flag",  underflow,                     1);
        check("unf_pulse", match_pulse | mismatch_pulse,  0);
        check("unf_err",   err_cnt,                       0);

        // Flush beats same-cycle compare
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 20 + i, 0, 0, 0);
        cycle(0, 0, 1, 20, 0);
        cycle(0, 0, 1, 21, 1);
        check("fl_level", level,                         0);
        check("fl_pulse", match_pulse | mismatch_pulse,  0);
        check("fl_mc",    match_cnt,                     1);
        check("fl_ready", exp_ready,                     1);

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 99) < 55, $urandom_range(0, 3),
                      $urandom_range(0, 99) < 45, $urandom_range(0, 3),
                      $urandom_range(0, 99) < 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/alu_scoreboard.md
ALU_SCOREBOARD -- requirements
Module: alu_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning result width.
REQ-002 SHALL have parameter DEPTH, default 8 (power of 2), meaning expected-result queue depth.
REQ-003 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port exp_valid  input  1  expected (golden) result present.
REQ-006 SHALL have port exp_data  input  DATA_W  expected result.
REQ-007 SHALL have port exp_ready  output  1  queue can accept exp_data.
REQ-008 SHALL have port act_valid  input  1  actual ALU result present.
REQ-009 SHALL have port act_data  input  DATA_W  actual ALU result.
REQ-010 SHALL have port flush  input  1  discard all queued expected results.
REQ-011 SHALL have port match_pulse / mismatch_pulse  output  1 each  one-cycle compare outcome.
REQ-012 SHALL have port mis_exp / mis_act  output  DATA_W each  operands of the last mismatch.
REQ-013 SHALL have port match_cnt / err_cnt  output  16 each  saturating counters.
REQ-014 SHALL have port overflow / underflow  output  1 each  sticky error flags.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  queued entry count.
REQ-016 SHALL have port halted  output  1  scoreboard stopped (see Configuration).

Function
REQ-020 SHALL push exp_data when exp_valid && exp_ready; exp_ready = (level < DEPTH) && !halted.
REQ-021 SHALL, on act_valid, pop the oldest queued entry and compare with act_data, in order.
REQ-022 SHALL register the compare: match_pulse or mismatch_pulse asserts exactly one cycle after act_valid.
REQ-023 SHALL, when the queue is empty and exp_valid && act_valid in the same cycle, compare act_data against exp_data directly (bypass, no push), level unchanged.
REQ-024 SHALL, when full and exp_valid && act_valid in the same cycle, accept both (pop plus push), no overflow.
REQ-025 SHALL set overflow when exp_valid && !exp_ready and not halted; SHALL set underflow when act_valid with empty queue and no bypass; neither counts as a mismatch.
REQ-026 SHALL latch mis_exp/mis_act on every mismatch; hold otherwise.
REQ-027 SHALL saturate match_cnt and err_cnt at 16'hFFFF.
REQ-028 SHALL use a state machine IDLE -> RUN on first accepted push; RUN -> HALT on mismatch (macro only); HALT left only by rst; flush returns RUN/IDLE to IDLE.
REQ-029 SHALL give flush priority over same-cycle push/pop: queue empties, pending compare of that cycle discarded, counters and sticky flags kept.
REQ-030 SHALL wrap read/write pointers modulo DEPTH.

Reset
REQ-040 SHALL on rst clear queue, level=0, state IDLE, exp_ready=1, halted=0, pulses=0, counters=0, flags=0, mis_exp=mis_act=0.
REQ-041 SHALL make rst mid-operation discard queued entries and any in-flight compare result.

Configuration
REQ-050 SHALL with ALU_SB_HALT_EN defined enter HALT on first mismatch: halted=1, exp_ready=0, act_valid ignored, counters frozen.
REQ-051 SHALL without ALU_SB_HALT_EN never enter HALT; halted tied 0; checking continues after mismatches.

Structure
REQ-060 SHALL place DATA_W/DEPTH defaults, counter width and the state enum (IDLE, RUN, HALT) in package alu_sb_pkg.
REQ-061 SHALL implement the queue as sub-module alu_sb_fifo (push, pop, flush, full, empty, level).

Verification
REQ-070 Push 3,6,9 then act 3,6,9 -> three match_pulse, match_cnt=3, err_cnt=0, level=0.
REQ-071 Push 5, act 7 -> mismatch_pulse, mis_exp=5, mis_act=7, err_cnt=1; with ALU_SB_HALT_EN halted=1 and exp_ready=0.
REQ-072 Empty queue, same-cycle exp=0x10 and act=0x10 -> match via bypass, level stays 0, no underflow.
REQ-073 Fill 8 entries, push 9th alone -> overflow=1, level=8; then same-cycle push/pop -> level=8, no new error.
REQ-074 act_valid on empty queue without exp_valid -> underflow=1, no pulse, err_cnt unchanged.
REQ-075 Push 4 entries, flush with simultaneous act_valid -> level=0, no pulse, state IDLE, counters unchanged.
